dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter and sequencer in front of the 16 x 10-bit DataMemory. It shares the single memory port between the pipeline MEM stage (CPU port) and a debug/loader port. It registers each granted command, drives the memory control lines for exactly one cycle, and returns registered read data with a valid strobe. It sits between the MEM stage and DataMemory; losing requesters stall in their own stage.

## Interface
Parameters:
- ADDR_W, 4, DataMemory address width
- DATA_W, 10, data word width
- STARVE_LIMIT, 4, consecutive denied cycles before the debug port is forced a grant (used only with DM_ARB_STARVE_EN)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  combinational; request accepted at this edge
- cpu_rvalid  out  1  read data valid, one-cycle pulse
- cpu_rdata  out  DATA_W  read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug port
- dm_write_en  out  1  to DataMemory write_en
- dm_mem_read  out  1  to DataMemory mem_read
- dm_address  out  ADDR_W  to DataMemory address
- dm_write_data  out  DATA_W  to DataMemory write_data
- dm_read_data  in  DATA_W  from DataMemory read_data; combinational, valid in the same cycle as address and mem_read

## Operation
- Grant, combinational from the current inputs and state:
  - CPU has fixed priority.
  - dbg_gnt = dbg_req & ~cpu_req, except when a forced grant is due (see Configuration).
  - At most one grant per cycle.
- Accept: on the edge where req & gnt, the command register latches {owner, we, addr, wdata} and the valid bit is set.
- FSM states:
  - IDLE: command register empty.
  - ACCESS: command register valid.
  - IDLE -> ACCESS on any grant.
  - ACCESS -> ACCESS on any grant.
  - ACCESS -> IDLE when there is no grant.
- In ACCESS:
  - dm_address = cmd addr.
  - dm_write_en = cmd we.
  - dm_mem_read = ~cmd we.
  - dm_write_data = cmd wdata.
- In IDLE: all dm_* outputs are 0.
- Read completion: at the end of an ACCESS read cycle, dm_read_data is captured into the owner's rdata register, and that owner's rvalid is set for one cycle.
- rdata holds its value until the next read for that owner.
- Writes produce no rvalid.
- Back-to-back accesses are fully pipelined, one per cycle. A new grant does not wait for the previous rvalid.

## Timing
- Reset, asynchronous assert and synchronous release:
  - State = IDLE, command valid = 0, starvation count = 0.
  - All dm_* = 0, both rvalid = 0, both rdata = 0.
  - Grants are 0 while rst_n is low.
- Read latency:
  - Accept at edge N.
  - Memory driven during cycle N..N+1.
  - rdata/rvalid registered at edge N+1, high for one cycle.
- Write latency: the memory write occurs at edge N+1.
- Read-after-write to the same address in consecutive commands returns the new data, because the write is committed one edge before the read's access cycle ends.
- Reset mid-access: the in-flight command is dropped and no rvalid is issued. Requesters re-issue after reset.
- A requester may change its command fields only after a gnt edge. req held without gnt means stalled, and the fields must stay stable.

## Configuration
- DM_ARB_STARVE_EN defined:
  - Counter increments on each cycle with dbg_req & ~dbg_gnt.
  - Counter clears on dbg_gnt or when dbg_req is low.
  - When count == STARVE_LIMIT, the next cycle forces dbg_gnt = dbg_req and cpu_gnt = 0.
  - Debug is therefore granted within STARVE_LIMIT+1 cycles.
- DM_ARB_STARVE_EN undefined: strict CPU priority. Debug can starve indefinitely. No counter logic exists.

## Structure
- Package dm_arb_pkg holds:
  - ADDR_W and DATA_W constants.
  - Owner enum: OWN_CPU = 0, OWN_DBG = 1.
  - FSM state enum: IDLE, ACCESS.
  - Command struct: owner, we, addr, wdata.
- Sub-module dm_arb_starve_cnt holds the starvation counter. Instantiate it only under DM_ARB_STARVE_EN.

## Test plan
- Reset: rst_n low mid-stream -> all outputs 0 immediately. After release, the first grant completes normally.
- CPU write 0x0A5 to addr 3, then CPU read addr 3 next cycle -> cpu_rvalid two edges after the read grant, cpu_rdata = 0x0A5, no dbg_rvalid.
- Simultaneous cpu_req and dbg_req, single cycle -> cpu_gnt = 1, dbg_gnt = 0. dbg granted the following cycle once cpu_req drops.
- Continuous cpu_req with dbg read of addr 5 holding 0x0E3, STARVE_EN defined, STARVE_LIMIT = 4 -> dbg_gnt on the 5th cycle, dbg_rdata = 0x0E3. Without the macro, dbg_gnt never asserts.
- Pipelined CPU reads of addr 0..15 on consecutive cycles -> 16 consecutive cpu_rvalid pulses with matching data. dm_address increments each cycle, no bubbles.
- No requests -> FSM returns to IDLE, dm_write_en = dm_mem_read = 0, rdata registers unchanged.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the DataMemory arbiter
//
// Contents: memory geometry constants, command owner encoding, sequencer
// state encoding and the packed command record.
package dm_arb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 10;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        owner_e              owner;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } cmd_t;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// rtl/dm_arb_starve_cnt.sv - debug-port starvation counter
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   dbg_req     : debug port is requesting
//   dbg_gnt     : debug port is granted this cycle
//   force_dbg   : debug has waited STARVE_LIMIT cycles; grant it now
module dm_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    // Saturates at LIMIT; the forced grant that follows clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Gated by dbg_req so a withdrawn debug request never blocks the CPU.
    assign force_dbg = dbg_req & (cnt == LIMIT);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port arbiter/sequencer in front of DataMemory
//
// Optional feature macro: DM_ARB_STARVE_EN (debug port starvation guard).
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_gnt     : CPU command port (fixed priority)
//   cpu_rvalid, cpu_rdata              : CPU read return
//   dbg_req/we/addr/wdata, dbg_gnt     : debug/loader command port
//   dbg_rvalid, dbg_rdata              : debug read return
//   dm_write_en, dm_mem_read,
//   dm_address, dm_write_data          : DataMemory control, driven for one cycle
//   dm_read_data                       : DataMemory combinational read data
module dm_arbiter #(
    parameter int ADDR_W       = dm_arb_pkg::ADDR_W,
    parameter int DATA_W       = dm_arb_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dm_write_en,
    output logic              dm_mem_read,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_write_data,
    input  logic [DATA_W-1:0] dm_read_data
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("dm_arbiter: STARVE_LIMIT must be at least 1");
    end

    dm_arb_pkg::state_e state;
    dm_arb_pkg::owner_e cmd_owner;
    logic               cmd_we;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;
    logic               force_dbg;
    logic               access;

`ifdef DM_ARB_STARVE_EN
    dm_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbg_req   (dbg_req),
        .dbg_gnt   (dbg_gnt),
        .force_dbg (force_dbg)
    );
`else
    assign force_dbg = 1'b0;
`endif

    // Grants are masked by rst_n so nothing is accepted while in reset.
    assign cpu_gnt = rst_n & cpu_req & ~force_dbg;
    assign dbg_gnt = rst_n & dbg_req & (~cpu_req | force_dbg);

    assign access        = (state == dm_arb_pkg::ACCESS);
    assign dm_write_en   = access & cmd_we;
    assign dm_mem_read   = access & ~cmd_we;
    assign dm_address    = access ? cmd_addr  : '0;
    assign dm_write_data = access ? cmd_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= dm_arb_pkg::IDLE;
            cmd_owner  <= dm_arb_pkg::OWN_CPU;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;

            // Retire the read occupying this access cycle to its owner.
            if (access && !cmd_we) begin
                if (cmd_owner == dm_arb_pkg::OWN_CPU) begin
                    cpu_rdata  <= dm_read_data;
                    cpu_rvalid <= 1'b1;
                end else begin
                    dbg_rdata  <= dm_read_data;
                    dbg_rvalid <= 1'b1;
                end
            end

            // A new command may be latched in the same edge, keeping the
            // memory busy every cycle under back-to-back requests.
            if (cpu_gnt) begin
                state     <= dm_arb_pkg::ACCESS;
                cmd_owner <= dm_arb_pkg::OWN_CPU;
                cmd_we    <= cpu_we;
                cmd_addr  <= cpu_addr;
                cmd_wdata <= cpu_wdata;
            end else if (dbg_gnt) begin
                state     <= dm_arb_pkg::ACCESS;
                cmd_owner <= dm_arb_pkg::OWN_DBG;
                cmd_we    <= dbg_we;
                cmd_addr  <= dbg_addr;
                cmd_wdata <= dbg_wdata;
            end else begin
                state <= dm_arb_pkg::IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard testbench for dm_arbiter
module tb_dm_arbiter;

    localparam int AW = 4;
    localparam int DW = 10;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          dm_write_en, dm_mem_read;
    logic [AW-1:0] dm_address;
    logic [DW-1:0] dm_write_data, dm_read_data;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dm_write_en(dm_write_en), .dm_mem_read(dm_mem_read), .dm_address(dm_address),
        .dm_write_data(dm_write_data), .dm_read_data(dm_read_data)
    );

    // DataMemory stand-in: combinational read, write on the clock edge.
    logic [DW-1:0] mem [16];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    assign dm_read_data = mem[dm_address];
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (dm_write_en) mem[dm_address] <= dm_write_data;
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q_cpu[$];
    exp_t          q_dbg[$];
    logic [DW-1:0] ref_mem [16];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;

    // Model state: command accepted at the previous edge.
    logic          la_v = 1'b0, la_we = 1'b0;
    logic [AW-1:0] la_addr = '0;
    logic [DW-1:0] la_wdata = '0;
    logic          cpu_hold = 1'b0, dbg_hold = 1'b0;
    logic          seen_dbg_gnt = 1'b0;
    logic [DW-1:0] last_cpu_rd = '0, last_dbg_rd = '0;
    int            scnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected read returns whenever the DUT strobes rvalid.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (cpu_rvalid) begin
                if (q_cpu.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL cpu_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q_cpu.pop_front();
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                    chk("cpu_rvalid_cycle", cyc, e.due);
                end
            end else if (q_cpu.size() > 0 && q_cpu[0].due <= cyc) begin
                e = q_cpu.pop_front();
                n_cmp++; n_err++;
                $display("FAIL cpu_rvalid_missing: got 0 expected 1 (cycle %0d)", cyc);
            end
            if (dbg_rvalid) begin
                if (q_dbg.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL dbg_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q_dbg.pop_front();
                    chk("dbg_rdata", 32'(dbg_rdata), 32'(e.data));
                    chk("dbg_rvalid_cycle", cyc, e.due);
                end
            end else if (q_dbg.size() > 0 && q_dbg[0].due <= cyc) begin
                e = q_dbg.pop_front();
                n_cmp++; n_err++;
                $display("FAIL dbg_rvalid_missing: got 0 expected 1 (cycle %0d)", cyc);
            end
        end
    end

    // One clock of stimulus: check memory drive and grants, update the model.
    task automatic step();
        logic force_d, e_cg, e_dg;
        @(negedge clk);
        chk("dm_write_en", 32'(dm_write_en), 32'(la_v & la_we));
        chk("dm_mem_read", 32'(dm_mem_read), 32'(la_v & ~la_we));
        chk("dm_address", 32'(dm_address), la_v ? 32'(la_addr) : 32'd0);
        chk("dm_write_data", 32'(dm_write_data), la_v ? 32'(la_wdata) : 32'd0);
        // The previous write commits before any read accepted now is sampled.
        if (la_v && la_we) ref_mem[la_addr] = la_wdata;
`ifdef DM_ARB_STARVE_EN
        force_d = dbg_req && (scnt == SL);
`else
        force_d = 1'b0;
`endif
        e_cg = cpu_req && !force_d;
        e_dg = dbg_req && (!cpu_req || force_d);
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
        seen_dbg_gnt = dbg_gnt;
        la_v = e_cg || e_dg;
        if (e_cg) begin
            la_we = cpu_we; la_addr = cpu_addr; la_wdata = cpu_wdata;
            if (!cpu_we) begin
                q_cpu.push_back('{ref_mem[cpu_addr], cyc + 2});
                last_cpu_rd = ref_mem[cpu_addr];
            end
        end else if (e_dg) begin
            la_we = dbg_we; la_addr = dbg_addr; la_wdata = dbg_wdata;
            if (!dbg_we) begin
                q_dbg.push_back('{ref_mem[dbg_addr], cyc + 2});
                last_dbg_rd = ref_mem[dbg_addr];
            end
        end
        cpu_hold = cpu_req && !e_cg;
        dbg_hold = dbg_req && !e_dg;
        scnt = (!dbg_req || e_dg) ? 0 : scnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic w, input int a, input int d);
        cpu_req = r; cpu_we = w; cpu_addr = AW'(a); cpu_wdata = DW'(d);
    endtask

    task automatic set_dbg(input logic r, input logic w, input int a, input int d);
        dbg_req = r; dbg_we = w; dbg_addr = AW'(a); dbg_wdata = DW'(d);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            if (!cpu_hold) set_cpu(($urandom % 3) != 0, $urandom % 2, $urandom % 16, $urandom % 1024);
            if (!dbg_hold) set_dbg(($urandom % 2) != 0, $urandom % 2, $urandom % 16, $urandom % 1024);
            step();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
        chk({tag, "_dbg_gnt"}, 32'(dbg_gnt), 0);
        chk({tag, "_dm_ctl"}, 32'({dm_write_en, dm_mem_read}), 0);
        chk({tag, "_dm_addr"}, 32'(dm_address), 0);
        chk({tag, "_dm_wdata"}, 32'(dm_write_data), 0);
        chk({tag, "_rvalid"}, 32'({cpu_rvalid, dbg_rvalid}), 0);
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
        chk({tag, "_dbg_rdata"}, 32'(dbg_rdata), 0);
    endtask

    task automatic model_reset();
        q_cpu.delete(); q_dbg.delete();
        la_v = 1'b0; cpu_hold = 1'b0; dbg_hold = 1'b0; scnt = 0;
        last_cpu_rd = '0; last_dbg_rd = '0;
    endtask

    initial begin
        int first_dbg;
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        // Preload memory while held in reset.
        for (int i = 0; i < 16; i++) begin
            pl_addr = AW'(i);
            pl_data = DW'($urandom % 1024);
            ref_mem[i] = pl_data;
            pl_en = 1'b1;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        set_cpu(1, 0, 2, 0);
        set_dbg(1, 1, 4, 9);
        #1 chk_all_zero("reset");
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // CPU write then read-after-write.
        set_cpu(1, 1, 3, 10'h0A5); step();
        set_cpu(1, 0, 3, 0);       step();
        set_cpu(0, 0, 0, 0);       step(); step();
        chk("raw_cpu_rdata", 32'(cpu_rdata), 32'h0A5);

        // Simultaneous requests; debug follows once CPU drops.
        set_cpu(1, 1, 7, $urandom % 1024);
        set_dbg(1, 0, 3, 0);
        step();
        set_cpu(0, 0, 0, 0);
        step();
        set_dbg(0, 0, 0, 0);
        step(); step();
        chk("dbg_after_cpu_rdata", 32'(dbg_rdata), 32'h0A5);

        // Continuous CPU traffic against a pending debug read.
        set_cpu(1, 1, 5, 10'h0E3); step();
        set_cpu(1, 0, 0, 0);
        set_dbg(1, 0, 5, 0);
        first_dbg = -1;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (seen_dbg_gnt) begin
                if (first_dbg < 0) first_dbg = s;
                set_dbg(0, 0, 0, 0);
            end
        end
`ifdef DM_ARB_STARVE_EN
        chk("starve_first_dbg_gnt", first_dbg, 5);
`else
        chk("starve_first_dbg_gnt", first_dbg, -1);
`endif
        set_cpu(0, 0, 0, 0);
        step();
        set_dbg(0, 0, 0, 0);
        step(); step();
        chk("starve_dbg_rdata", 32'(dbg_rdata), 32'h0E3);

        // Pipelined CPU reads across the whole memory.
        for (int a = 0; a < 16; a++) begin
            set_cpu(1, 0, a, 0);
            step();
        end
        set_cpu(0, 0, 0, 0);
        step(); step(); step();

        // Idle: memory lines quiet, read registers hold.
        step(); step();
        chk("idle_cpu_rdata_hold", 32'(cpu_rdata), 32'(last_cpu_rd));
        chk("idle_dbg_rdata_hold", 32'(dbg_rdata), 32'(last_dbg_rd));

        rand_steps(300);

        // Reset in the middle of traffic.
        set_cpu(1, 0, $urandom % 16, 0);
        set_dbg(1, 1, $urandom % 16, $urandom % 1024);
        step();
        set_cpu(1, 0, $urandom % 16, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        model_reset();
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        rand_steps(60);

        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        step(); step(); step(); step();
        chk("drain_cpu_queue", q_cpu.size(), 0);
        chk("drain_dbg_queue", q_dbg.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
